roll_button_conditioner: RTL and testbench

- Upstream stage of the dice roller; converts a raw, bouncy push-button into the single-cycle ROLL pulse the dice block consumes.
- Synchronises the button, debounces press and release, and emits one pulse per accepted press.
- Locks out new rolls while the dice is still spinning, using the dice's decimal-point LED (LEDS[7], high = settled) fed back as SETTLED.
- Keeps an 8-bit count of accepted rolls for debug or display.

---
 rtl/dice_pkg.sv | 16 +
 rtl/sync_2ff.sv | 25 ++
 rtl/roll_button_conditioner.sv | 136 +++++++++++++
 tb/tb_roll_button_conditioner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller front end: button FSM encoding,
// roll counter width and default timing constants.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_e;

  localparam int ROLL_COUNT_W        = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_CYCLES_DEF   = 4096;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; async active-low
// reset clears both flops to 0.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign dout = sync_p1;

endmodule

// File: rtl/roll_button_conditioner.sv
// Turns a bouncy push-button into one ROLL pulse per debounced press, locked
// out while the dice is spinning. Optional auto-repeat: BTN_AUTOREPEAT_EN.
module roll_button_conditioner
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    BTN,
  input  logic                    SETTLED,
  output logic                    ROLL,
  output logic                    BTN_LEVEL,
  output logic [ROLL_COUNT_W-1:0] ROLL_COUNT
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic                    s;
  btn_state_e              state_p0, state_nxt;
  logic [CNT_W-1:0]        cnt_p0, cnt_nxt;
  logic                    level_p0, level_nxt;
  logic                    roll_p0, roll_nxt;
  logic [ROLL_COUNT_W-1:0] count_p0, count_nxt;

  // Stage: synchronise the raw button into the CLK domain
  sync_2ff u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .din  (BTN),
    .dout (s)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES);

  logic [RPT_W-1:0] rpt_p0, rpt_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rpt_p0 <= '0;
    else      rpt_p0 <= rpt_nxt;
  end
`else
  logic unused_rpt;
  assign unused_rpt = (REPEAT_CYCLES > 0);
`endif

  // Stage: debounce FSM and roll generation
  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    level_nxt = level_p0;
    roll_nxt  = 1'b0;
    count_nxt = count_p0;
    case (state_p0)
      IDLE: begin
        if (s) begin
          state_nxt = ARM_PRESS;
          cnt_nxt   = CNT_ONE;
        end
      end
      ARM_PRESS: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_p0 >= CNT_LAST) begin
          // SETTLED matters only on this accepting edge
          state_nxt = HELD;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          roll_nxt  = SETTLED;
        end else begin
          cnt_nxt = sat_inc(cnt_p0);
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = ARM_RELEASE;
          cnt_nxt   = CNT_ONE;
        end
      end
      ARM_RELEASE: begin
        if (s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt_p0 >= CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = sat_inc(cnt_p0);
        end
      end
    endcase
`ifdef BTN_AUTOREPEAT_EN
    rpt_nxt = '0;
    if (state_p0 == HELD && state_nxt == HELD) begin
      if (rpt_p0 + RPT_W'(1) == RPT_LAST) begin
        roll_nxt = SETTLED;
      end else begin
        rpt_nxt = rpt_p0 + RPT_W'(1);
      end
    end
`endif
    if (roll_nxt) count_nxt = count_p0 + ROLL_COUNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      level_p0 <= 1'b0;
      roll_p0  <= 1'b0;
      count_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      level_p0 <= level_nxt;
      roll_p0  <= roll_nxt;
      count_p0 <= count_nxt;
    end
  end

  assign ROLL       = roll_p0;
  assign BTN_LEVEL  = level_p0;
  assign ROLL_COUNT = count_p0;

endmodule

// File: tb/tb_roll_button_conditioner.sv
// Bench for roll_button_conditioner: table vectors, corner sequences and a
// random run against a run-length debounce model.
module tb_roll_button_conditioner;

  localparam int DEB = 4;
  localparam int REP = 10;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN;
  logic       SETTLED;
  logic       ROLL;
  logic       BTN_LEVEL;
  logic [7:0] ROLL_COUNT;

  always #5 CLK = ~CLK;

  roll_button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN        (BTN),
    .SETTLED    (SETTLED),
    .ROLL       (ROLL),
    .BTN_LEVEL  (BTN_LEVEL),
    .ROLL_COUNT (ROLL_COUNT)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a press/release is accepted on the DEB-th consecutive synchronised
  // sample that differs from the current debounced level.
  bit m_h1, m_h2, m_level, m_roll;
  int m_run, m_rep, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_h1 = 0; m_h2 = 0; m_level = 0; m_roll = 0;
    m_run = 0; m_rep = 0; m_cnt = 0;
  endfunction

  function automatic void m_edge(input bit b, input bit st, input bit r);
    bit s, flipped, held_before;
    if (!r) begin
      m_reset();
      return;
    end
    s = m_h2; m_h2 = m_h1; m_h1 = b;
    m_roll = 0;
    flipped = 0;
    held_before = m_level && (m_run == 0);
    if (s != m_level) m_run++;
    else              m_run = 0;
    if (m_run == DEB) begin
      m_level = s; m_run = 0; flipped = 1;
      if (s && st) begin m_roll = 1; m_cnt = (m_cnt + 1) % 256; end
    end
`ifdef BTN_AUTOREPEAT_EN
    if (!flipped && held_before && m_run == 0) begin
      m_rep++;
      if (m_rep == REP) begin
        m_rep = 0;
        if (st) begin m_roll = 1; m_cnt = (m_cnt + 1) % 256; end
      end
    end else begin
      m_rep = 0;
    end
`else
    if (flipped && held_before) m_rep = 0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    m_edge(BTN, SETTLED, RST);
    #1;
    chk("model_roll", ROLL, m_roll);
    chk("model_level", BTN_LEVEL, m_level);
    chk("model_count", ROLL_COUNT, m_cnt);
  endtask

  typedef struct {
    bit btn;
    bit st;
    bit roll;
    bit lvl;
    int cnt;
  } vec_t;

  vec_t tbl[18];
  int   nroll, first, hold;
  int   rp[$];
  bit   prev_roll;

  initial begin
    // clean press then clean release, starting from a reset, idle button
    for (int i = 0; i < 5; i++)   tbl[i] = '{1, 1, 0, 0, 0};
    tbl[5] = '{1, 1, 1, 1, 1};
    for (int i = 6; i < 10; i++)  tbl[i] = '{1, 1, 0, 1, 1};
    for (int i = 10; i < 15; i++) tbl[i] = '{0, 1, 0, 1, 1};
    for (int i = 15; i < 18; i++) tbl[i] = '{0, 1, 0, 0, 1};

    RST = 1'b0; BTN = 1'b0; SETTLED = 1'b1;
    m_reset();
    repeat (3) tick();
    chk("reset_roll", ROLL, 0);
    chk("reset_level", BTN_LEVEL, 0);
    chk("reset_count", ROLL_COUNT, 0);
    RST = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 18; i++) begin
      BTN = tbl[i].btn; SETTLED = tbl[i].st;
      tick();
      chk($sformatf("tbl%0d_roll", i), ROLL, tbl[i].roll);
      chk($sformatf("tbl%0d_level", i), BTN_LEVEL, tbl[i].lvl);
      chk($sformatf("tbl%0d_count", i), ROLL_COUNT, tbl[i].cnt);
    end

    // bounce shorter than the debounce window
    nroll = 0;
    foreach (tbl[i]) if (i < 12) begin
      BTN = (i == 0 || i == 1 || i == 3 || i == 4);
      tick();
      nroll += ROLL;
    end
    chk("bounce_rolls", nroll, 0);
    chk("bounce_level", BTN_LEVEL, 0);
    chk("bounce_count", ROLL_COUNT, 1);

    // lockout while the dice is spinning
    SETTLED = 1'b0; BTN = 1'b1; nroll = 0;
    repeat (10) begin tick(); nroll += ROLL; end
    chk("lock_rolls", nroll, 0);
    chk("lock_level", BTN_LEVEL, 1);
    chk("lock_count", ROLL_COUNT, 1);
    BTN = 1'b0;
    repeat (10) tick();
    SETTLED = 1'b1; BTN = 1'b1; nroll = 0;
    repeat (10) begin tick(); nroll += ROLL; end
    chk("unlock_rolls", nroll, 1);
    chk("unlock_count", ROLL_COUNT, 2);

    // release bounce while held
    BTN = 1'b0; nroll = 0;
    repeat (2) begin tick(); nroll += ROLL; end
    BTN = 1'b1;
    repeat (10) begin tick(); nroll += ROLL; end
    chk("relbounce_rolls", nroll, 0);
    chk("relbounce_level", BTN_LEVEL, 1);
    BTN = 1'b0;
    repeat (10) tick();
    chk("release_level", BTN_LEVEL, 0);
    chk("release_count", ROLL_COUNT, 2);

    // reset in the middle of a press
    BTN = 1'b1;
    repeat (4) tick();
    #2;
    RST = 1'b0;
    m_reset();
    #1;
    chk("rstmid_roll", ROLL, 0);
    chk("rstmid_level", BTN_LEVEL, 0);
    chk("rstmid_count", ROLL_COUNT, 0);
    repeat (2) tick();
    RST = 1'b1;
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (ROLL && first == 0) first = e;
    end
    chk("rstmid_latency", first, DEB + 2);
    BTN = 1'b0;
    repeat (10) tick();

    // 256 accepted presses wrap the counter
    RST = 1'b0; m_reset();
    tick();
    RST = 1'b1;
    repeat (2) tick();
    chk("wrap_start", ROLL_COUNT, 0);
    nroll = 0;
    for (int p = 0; p < 256; p++) begin
      BTN = 1'b1; repeat (7) begin tick(); nroll += ROLL; end
      BTN = 1'b0; repeat (7) begin tick(); nroll += ROLL; end
    end
    chk("wrap_rolls", nroll, 256);
    chk("wrap_count", ROLL_COUNT, 0);

`ifdef BTN_AUTOREPEAT_EN
    BTN = 1'b1; first = 0;
    for (int e = 1; e <= 20 && first == 0; e++) begin
      tick();
      if (ROLL) first = e;
    end
    chk("rpt_accept", first, DEB + 2);
    for (int e = 1; e <= 35; e++) begin
      tick();
      if (ROLL) rp.push_back(e);
    end
    chk("rpt_pulses", rp.size(), 3);
    foreach (rp[i]) chk($sformatf("rpt_at%0d", i), rp[i], (i + 1) * REP);
    BTN = 1'b0;
    repeat (10) tick();
`endif

    // random bursty button against the model
    hold = 0; prev_roll = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        BTN = 1'($urandom_range(0, 1));
        SETTLED = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 8);
      end
      hold--;
      tick();
      chk("roll_pair", prev_roll && ROLL, 0);
      prev_roll = ROLL;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
